// File: rtl/csr_pkg.sv
// Shared CSR addresses, trap cause codes and controller states for csr_irq_unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MIE_EXT   = 12'h7C0;
  localparam logic [11:0] CSR_MEXTID    = 12'h7C1;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [4:0] CAUSE_MEI = 5'd11;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] EXT_BASE  = 5'd16;

  typedef enum logic [1:0] {IDLE, PENDING, ISR} state_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half CSR load; a load takes precedence over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt controller: N prioritised external lines, timer,
// direct/vectored mtvec and live mcycle/minstret.
//   state   | meaning
//   IDLE    | normal execution, interrupts sampled when MIE set
//   PENDING | trap accepted, waiting for a non-bubble instruction to redirect
//   ISR     | handler running, interrupts ignored until mret
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int          N_EXT_IRQ   = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          csr_addr,
  output logic [31:0]          csr_rdata,
  input  logic [31:0]          csr_wdata,
  input  logic                 csr_wen,
  input  logic                 retire,
  input  logic                 stall,
  input  logic                 nop,
  input  logic [31:0]          pc,
  input  logic                 mret,
  input  logic [N_EXT_IRQ-1:0] ext_irq,
  input  logic                 tm_irq,
  output logic                 trap_taken,
  output logic [31:0]          trap_target,
  output logic [31:0]          mret_target
);

  state_t                 state;
  logic                   st_mie, st_mpie, meie, mtie;
  logic [1:0]             st_mpp;
  logic [N_EXT_IRQ-1:0]   mie_ext;
  logic [31:0]            mtvec, mepc, mcause;
  logic [3:0]             mextid, claim_id;
  logic [63:0]            mcycle, minstret;
  logic                   wr, meip, irq_ext, irq_tm, take;
  logic [4:0]             vec_idx;
  logic [31:0]            tvec_base;

  assign wr      = csr_wen && !stall;
  assign meip    = |(ext_irq & mie_ext);
  assign irq_ext = meie && meip;
  assign irq_tm  = mtie && tm_irq;
  assign take    = st_mie && (irq_ext || irq_tm);

  // lowest-index enabled pending line wins
  always_comb begin
    claim_id = '0;
    for (int i = N_EXT_IRQ - 1; i >= 0; i--)
      if (ext_irq[i] && mie_ext[i]) claim_id = 4'(i);
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr && csr_addr == CSR_MCYCLE),
    .wr_hi (wr && csr_addr == CSR_MCYCLEH),
    .wdata (csr_wdata),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire && !stall),
    .wr_lo (wr && csr_addr == CSR_MINSTRET),
    .wr_hi (wr && csr_addr == CSR_MINSTRETH),
    .wdata (csr_wdata),
    .value (minstret)
  );

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MIE:       csr_rdata = {20'b0, meie, 3'b0, mtie, 7'b0};
      CSR_MTVEC:     csr_rdata = {mtvec[31:2], (mtvec[1] ? 2'b00 : mtvec[1:0])};
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MIP:       csr_rdata = {20'b0, meip, 3'b0, tm_irq, 7'b0};
      CSR_MIE_EXT:   csr_rdata = 32'(mie_ext);
      CSR_MEXTID:    csr_rdata = 32'(mextid);
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      default:       csr_rdata = '0;
    endcase
  end

  always_comb begin
    vec_idx = CAUSE_MTI;
    if (mcause[4:0] == CAUSE_MEI)
      vec_idx = (mextid != 4'd0) ? EXT_BASE + 5'(mextid) : CAUSE_MEI;
  end

  assign tvec_base   = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[1:0] == 2'b01) ? tvec_base + {25'b0, vec_idx, 2'b00} : tvec_base;
  assign trap_taken  = (state == PENDING) && !nop;
  assign mret_target = mepc;

  // CSR writes first; hardware updates below override them in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      st_mpp  <= 2'b00;
      meie    <= 1'b0;
      mtie    <= 1'b0;
      mie_ext <= '0;
      mtvec   <= MTVEC_RESET;
      mepc    <= '0;
      mcause  <= '0;
      mextid  <= '0;
    end else if (!stall) begin
      if (wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mpp  <= csr_wdata[12:11];
            st_mpie <= csr_wdata[7];
            st_mie  <= csr_wdata[3];
          end
          CSR_MIE: begin
            meie <= csr_wdata[11];
            mtie <= csr_wdata[7];
          end
          CSR_MTVEC:   mtvec   <= VECTORED_EN ? csr_wdata : {csr_wdata[31:2], 2'b00};
          CSR_MEPC:    mepc    <= {csr_wdata[31:2], 2'b00};
          CSR_MIE_EXT: mie_ext <= csr_wdata[N_EXT_IRQ-1:0];
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (take) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            st_mpp  <= 2'b11;
            mcause  <= {1'b1, 26'b0, (irq_ext ? CAUSE_MEI : CAUSE_MTI)};
            if (irq_ext) mextid <= claim_id;
            state   <= PENDING;
          end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
            st_mpp  <= 2'b11;
          end
        end
        PENDING: begin
          if (!nop) begin
            mepc  <= pc + 32'd4;
            state <= ISR;
          end
        end
        ISR: begin
          if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
            st_mpp  <= 2'b11;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed bench for csr_irq_unit: trap entry/exit, vectoring, stall, counters, collisions, reset.
module tb_csr_irq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        retire;
  logic        stall;
  logic        nop;
  logic [31:0] pc;
  logic        mret;
  logic [3:0]  ext_irq;
  logic        tm_irq;
  logic        trap_taken;
  logic [31:0] trap_target;
  logic [31:0] mret_target;

  int n_tests = 0;
  int n_fail  = 0;

  csr_irq_unit #(
    .N_EXT_IRQ   (4),
    .MTVEC_RESET (32'h0001_0000),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_addr    (csr_addr),
    .csr_rdata   (csr_rdata),
    .csr_wdata   (csr_wdata),
    .csr_wen     (csr_wen),
    .retire      (retire),
    .stall       (stall),
    .nop         (nop),
    .pc          (pc),
    .mret        (mret),
    .ext_irq     (ext_irq),
    .tm_irq      (tm_irq),
    .trap_taken  (trap_taken),
    .trap_target (trap_target),
    .mret_target (mret_target)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    tick();
    csr_wen   = 1'b0;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; csr_addr = '0; csr_wdata = '0; csr_wen = 1'b0; retire = 1'b0;
    stall = 1'b0; nop = 1'b0; pc = '0; mret = 1'b0; ext_irq = '0; tm_irq = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_eq("rst_trap_taken", trap_taken, 32'd0);
    chk_csr("rst_mtvec", 12'h305, 32'h0001_0000);
    chk_csr("rst_mstatus", 12'h300, 32'h0);
    chk_csr("rst_mextid", 12'h7C1, 32'h0);
    chk_csr("rst_mepc", 12'h341, 32'h0);

    // external trap, direct mode, line 1 claimed over line 2
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    wr(12'h7C0, 32'h6);
    ext_irq = 4'b0110; pc = 32'h100;
    chk_csr("mip_ext", 12'h344, 32'h800);
    tick();
    check_eq("ext_trap_taken", trap_taken, 32'd1);
    check_eq("ext_target_direct", trap_target, 32'h0001_0000);
    tick();
    ext_irq = '0;
    check_eq("ext_isr_no_trap", trap_taken, 32'd0);
    chk_csr("ext_mepc", 12'h341, 32'h104);
    chk_csr("ext_mcause", 12'h342, 32'h8000_000B);
    chk_csr("ext_mextid", 12'h7C1, 32'h1);
    chk_csr("ext_mstatus", 12'h300, 32'h1880);
    check_eq("ext_mret_target", mret_target, 32'h104);
    mret = 1'b1; tick(); mret = 1'b0;
    chk_csr("ext_mret_mstatus", 12'h300, 32'h1888);

    // timer trap, vectored mode
    wr(12'h305, 32'h0001_0001);
    wr(12'h304, 32'h080);
    tm_irq = 1'b1; pc = 32'h300;
    tick();
    check_eq("tm_trap_taken", trap_taken, 32'd1);
    check_eq("tm_target_vec", trap_target, 32'h0001_001C);
    tick();
    tm_irq = 1'b0;
    chk_csr("tm_mcause", 12'h342, 32'h8000_0007);
    chk_csr("tm_mepc", 12'h341, 32'h304);
    mret = 1'b1; tick(); mret = 1'b0;
    chk_csr("tm_mret_mstatus", 12'h300, 32'h1888);
    check_eq("tm_mret_target", mret_target, 32'h304);

    // stall freezes everything but mcycle
    wr(12'hB00, 32'd100);
    stall = 1'b1; retire = 1'b1; tm_irq = 1'b1;
    repeat (5) tick();
    check_eq("stall_no_trap", trap_taken, 32'd0);
    chk_csr("stall_mcycle", 12'hB00, 32'd105);
    chk_csr("stall_minstret", 12'hB02, 32'd0);
    chk_csr("stall_mepc", 12'h341, 32'h304);

    // trap taken once stall releases, then held by bubbles
    stall = 1'b0;
    tick();
    check_eq("unstall_trap", trap_taken, 32'd1);
    nop = 1'b1; tm_irq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("nop_hold", trap_taken, 32'd0);
    end
    nop = 1'b0; pc = 32'h200;
    #1;
    check_eq("nop_release_trap", trap_taken, 32'd1);
    check_eq("nop_release_target", trap_target, 32'h0001_001C);
    tick();
    retire = 1'b0;
    check_eq("nop_isr_no_trap", trap_taken, 32'd0);
    chk_csr("nop_mepc", 12'h341, 32'h204);
    chk_csr("nop_minstret", 12'hB02, 32'd5);
    mret = 1'b1; tick(); mret = 1'b0;

    // 64-bit carry after half writes
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    chk_csr("wrap_lo_held", 12'hB00, 32'hFFFF_FFFF);
    tick();
    chk_csr("wrap_hi", 12'hB80, 32'h1);
    chk_csr("wrap_lo", 12'hB00, 32'h0);
    wr(12'hB82, 32'h7);
    chk_csr("minstreth_wr", 12'hB82, 32'h7);
    chk_csr("minstret_lo_held", 12'hB02, 32'd5);

    // hardware update beats same-cycle CSR write
    tm_irq = 1'b1;
    wr(12'h300, 32'h0);
    check_eq("coll_trap_taken", trap_taken, 32'd1);
    chk_csr("coll_mstatus_entry", 12'h300, 32'h1880);
    tm_irq = 1'b0; pc = 32'h400;
    wr(12'h341, 32'hDEAD_BEE0);
    check_eq("coll_isr_no_trap", trap_taken, 32'd0);
    chk_csr("coll_mepc", 12'h341, 32'h404);
    mret = 1'b1;
    wr(12'h300, 32'h0);
    mret = 1'b0;
    chk_csr("coll_mstatus_mret", 12'h300, 32'h1888);

    // field legalisation and unmapped addresses
    wr(12'h341, 32'h1237);
    chk_csr("mepc_align", 12'h341, 32'h1234);
    wr(12'h305, 32'h0001_0003);
    chk_csr("mtvec_mode_1x", 12'h305, 32'h0001_0000);
    chk_csr("unmapped", 12'h123, 32'h0);
    chk_csr("mie_rd", 12'h304, 32'h80);
    chk_csr("mie_ext_rd", 12'h7C0, 32'h6);

    // vectored external with nonzero line id
    wr(12'h305, 32'h0001_0001);
    wr(12'h304, 32'h800);
    ext_irq = 4'b0110; pc = 32'h500;
    tick();
    check_eq("vext_trap_taken", trap_taken, 32'd1);
    check_eq("vext_target", trap_target, 32'h0001_0044);
    tick();
    chk_csr("vext_mextid", 12'h7C1, 32'h1);
    chk_csr("vext_mcause", 12'h342, 32'h8000_000B);

    // reset in the middle of the handler
    rst = 1'b1;
    #1;
    check_eq("isr_rst_trap", trap_taken, 32'd0);
    chk_csr("isr_rst_mstatus", 12'h300, 32'h0);
    chk_csr("isr_rst_mtvec", 12'h305, 32'h0001_0000);
    chk_csr("isr_rst_mepc", 12'h341, 32'h0);
    chk_csr("isr_rst_mie_ext", 12'h7C0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_no_trap", trap_taken, 32'd0);
    chk_csr("post_rst_minstret", 12'hB02, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
